// File: rtl/toggle_chk_pkg.sv
// Shared types for the toggle-stage checker.
//
// kind_e  : violation classes carried in each error-log record.
// state_e : monitor sequencing (reset observation, baseline capture, full checking).
// rec_t   : one error-log record. The hist field exists only when TOGGLE_CHK_HIST_EN
//           is defined, so the default build carries no history storage at all.
//
// Record field widths come from the package defaults below. The monitor's CNT_W and
// HIST_LEN parameters default to these values and must not exceed them.
package toggle_chk_pkg;

  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned HIST_LEN_DEF = 4;

  localparam int unsigned REC_STAMP_W = CNT_W_DEF;
  localparam int unsigned REC_HIST_W  = 2 * HIST_LEN_DEF;

  typedef enum logic [1:0] {
    KIND_TOGGLE = 2'd0,
    KIND_Z      = 2'd1,
    KIND_RSTVAL = 2'd2
  } kind_e;

  typedef enum logic [1:0] {
    ST_RST,
    ST_ARM,
    ST_RUN
  } state_e;

  typedef struct packed {
    kind_e                  kind;
    logic [REC_STAMP_W-1:0] stamp;
`ifdef TOGGLE_CHK_HIST_EN
    logic [REC_HIST_W-1:0]  hist;
`endif
  } rec_t;

  // One record per cycle, so simultaneous hits collapse onto the most severe class.
  function automatic kind_e pick_kind(input logic hit_rstval, input logic hit_toggle);
    if (hit_rstval) begin
      return KIND_RSTVAL;
    end else if (hit_toggle) begin
      return KIND_TOGGLE;
    end
    return KIND_Z;
  endfunction

endpackage

// File: rtl/toggle_chk_fifo.sv
// Synchronous FIFO of error-log records for the toggle checker.
//
// Ports
//   clk    in   clock
//   reset  in   synchronous active-high reset; empties the FIFO
//   push   in   write wdata (ignored when full unless popping the same cycle)
//   wdata  in   record to write
//   pop    in   remove head record (ignored when empty)
//   rdata  out  head record, valid while !empty
//   full   out  all DEPTH entries occupied
//   empty  out  no entries
//
// DEPTH must be a power of two and at least 2. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module toggle_chk_fifo
  import toggle_chk_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  rec_t wdata,
  input  logic pop,
  output rec_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  rec_t        mem [DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic        do_push;
  logic        do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A pop frees the head slot this same edge, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
    end
  end

  // Payload storage needs no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/toggle_chk_monitor.sv
// Passive checker for the toggle stage. Observes en, q and z every cycle and checks
//   - q is 0 on the first cycle after any cycle with reset high   (KIND_RSTVAL)
//   - q(t+1) == q(t) ^ en(t)                                       (KIND_TOGGLE)
//   - z == q ^ en                                                  (KIND_Z)
// Each violating cycle bumps a saturating counter, sets a sticky fail flag and pushes
// one record (kind, cycle stamp[, history]) into a small log FIFO drained by
// err_valid/err_ready. Records arriving while the FIFO is full and not popping are
// counted in drop_cnt.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous active-high reset (shared with the observed stage)
//   en, q, z   in   observed toggle-stage signals
//   fail       out  sticky: any violation since reset
//   viol_cnt   out  saturating violation count
//   drop_cnt   out  saturating count of records lost to a full FIFO
//   err_valid  out  head record available
//   err_ready  in   consumer takes the head record
//   err_kind   out  kind_e of head record
//   err_stamp  out  cycle stamp of head record
//   err_hist   out  {q,en} history of head record, oldest in MSBs (0 unless enabled)
//
// Build option: define TOGGLE_CHK_HIST_EN to keep a HIST_LEN-deep {q,en} history that
// shifts on every checking cycle and is snapshotted into each record.
module toggle_chk_monitor
  import toggle_chk_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned HIST_LEN = HIST_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  q,
  input  logic                  z,
  output logic                  fail,
  output logic [CNT_W-1:0]      viol_cnt,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  err_valid,
  input  logic                  err_ready,
  output logic [1:0]            err_kind,
  output logic [CNT_W-1:0]      err_stamp,
  output logic [2*HIST_LEN-1:0] err_hist
);

  localparam int unsigned HW = 2 * HIST_LEN;

  state_e state_q;
  state_e state_d;
  logic   chk_rst;
  logic   chk_run;

  logic             rst_prev_q;
  logic             q_prev_q;
  logic             en_prev_q;
  logic [CNT_W-1:0] stamp_q;
  logic             fail_q;
  logic [CNT_W-1:0] viol_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic  hit_rstval;
  logic  hit_toggle;
  logic  hit_z;
  logic  viol;
  logic  drop;
  logic  pop;
  logic  fifo_full;
  logic  fifo_empty;
  rec_t  wr_rec;
  rec_t  head;

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST:  state_d = ST_ARM;
      ST_ARM:  state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RST;
    endcase
  end

  // ARM enables nothing: its sample only becomes the baseline for the first RUN check.
  always_comb begin
    chk_rst = 1'b0;
    chk_run = 1'b0;
    unique case (state_q)
      ST_RST:  chk_rst = 1'b1;
      ST_RUN:  chk_run = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Detection on the current cycle's samples
  // ---------------------------------------------------------------------------
  assign hit_rstval = chk_rst & rst_prev_q & q;
  assign hit_toggle = chk_run & (q != (q_prev_q ^ en_prev_q));
  assign hit_z      = chk_run & (z != (q ^ en));
  assign viol       = hit_rstval | hit_toggle | hit_z;

  assign pop  = err_ready & ~fifo_empty;
  assign drop = viol & fifo_full & ~pop;

  // ---------------------------------------------------------------------------
  // Optional {q,en} history
  // ---------------------------------------------------------------------------
`ifdef TOGGLE_CHK_HIST_EN
  logic [HW-1:0] hist_q;
  logic [HW-1:0] hist_now;

  // The snapshot includes the current sample, so a record shows the violating cycle last.
  assign hist_now = chk_run ? {hist_q[HW-3:0], q, en} : hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_now;
    end
  end
`endif

  always_comb begin
    wr_rec       = '0;
    wr_rec.kind  = pick_kind(hit_rstval, hit_toggle);
    wr_rec.stamp = REC_STAMP_W'(stamp_q);
`ifdef TOGGLE_CHK_HIST_EN
    wr_rec.hist  = REC_HIST_W'(hist_now);
`endif
  end

  // ---------------------------------------------------------------------------
  // Sample history, stamp, status and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_prev_q <= 1'b1;
      q_prev_q   <= 1'b0;
      en_prev_q  <= 1'b0;
      stamp_q    <= '0;
      fail_q     <= 1'b0;
      viol_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      rst_prev_q <= 1'b0;
      q_prev_q   <= q;
      en_prev_q  <= en;
      if (chk_run && (stamp_q != '1)) begin
        stamp_q <= stamp_q + CNT_W'(1);
      end
      if (viol) begin
        fail_q <= 1'b1;
      end
      if (viol && (viol_cnt_q != '1)) begin
        viol_cnt_q <= viol_cnt_q + CNT_W'(1);
      end
      if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error log
  // ---------------------------------------------------------------------------
  toggle_chk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (viol),
    .wdata (wr_rec),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fail      = fail_q;
  assign viol_cnt  = viol_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign err_valid = ~fifo_empty;
  assign err_kind  = head.kind;
  assign err_stamp = CNT_W'(head.stamp);
`ifdef TOGGLE_CHK_HIST_EN
  assign err_hist  = HW'(head.hist);
`else
  assign err_hist  = '0;
`endif

endmodule

// File: tb/tb_toggle_chk_monitor.sv
// Directed bench for toggle_chk_monitor. Inputs change 1ns after the rising edge and
// outputs are sampled at that same point, so every observation reflects the last edge.
module tb_toggle_chk_monitor;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned HIST_LEN = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  en = 1'b0;
  logic                  q = 1'b0;
  logic                  z = 1'b0;
  logic                  err_ready = 1'b0;
  logic                  fail;
  logic [CNT_W-1:0]      viol_cnt;
  logic [CNT_W-1:0]      drop_cnt;
  logic                  err_valid;
  logic [1:0]            err_kind;
  logic [CNT_W-1:0]      err_stamp;
  logic [2*HIST_LEN-1:0] err_hist;

  int  checks = 0;
  int  errors = 0;
  logic tq = 1'b0;  // well-behaved toggle state used when driving a correct stage

  always #5 clk = ~clk;

  toggle_chk_monitor #(
    .CNT_W    (CNT_W),
    .DEPTH    (4),
    .HIST_LEN (HIST_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .q         (q),
    .z         (z),
    .fail      (fail),
    .viol_cnt  (viol_cnt),
    .drop_cnt  (drop_cnt),
    .err_valid (err_valid),
    .err_ready (err_ready),
    .err_kind  (err_kind),
    .err_stamp (err_stamp),
    .err_hist  (err_hist)
  );

  task automatic step(input logic r, input logic e, input logic qv, input logic zv);
    reset = r;
    en    = e;
    q     = qv;
    z     = zv;
    @(posedge clk);
    #1;
  endtask

  task automatic good(input logic e);
    step(1'b0, e, tq, tq ^ e);
    tq = tq ^ e;
  endtask

  // Reset for n cycles, then the RST and ARM cycles, leaving the monitor in RUN.
  task automatic to_run(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
    tq = 1'b0;
    good(1'b0);
    good(1'b0);
  endtask

  task automatic test_reset;
    logic seen_valid;
    err_ready = 1'b1;
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    tq = 1'b0;
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b want 0", fail); end
    checks++; if (viol_cnt !== 16'd0) begin errors++; $display("FAIL reset_viol: got %0d want 0", viol_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", err_valid); end
    seen_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      good(logic'(i % 2 == 0));
      if (err_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL clean_valid: got %b want 0", seen_valid); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL clean_fail: got %b want 0", fail); end
    checks++; if (viol_cnt !== 16'd0) begin errors++; $display("FAIL clean_viol: got %0d want 0", viol_cnt); end
  endtask

  task automatic test_toggle;
    err_ready = 1'b0;
    to_run(2);
    step(1'b0, 1'b0, 1'b1, 1'b1);  // q jumps with en=0, stamp 0
    checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL tog_valid: got %b want 1", err_valid); end
    checks++; if (err_kind !== 2'd0) begin errors++; $display("FAIL tog_kind: got %0d want 0", err_kind); end
    checks++; if (err_stamp !== 16'd0) begin errors++; $display("FAIL tog_stamp: got %0d want 0", err_stamp); end
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL tog_fail: got %b want 1", fail); end
    checks++; if (viol_cnt !== 16'd1) begin errors++; $display("FAIL tog_viol: got %0d want 1", viol_cnt); end
    // Returning q to 0 with en=0 breaks the contract again (expected 1), stamp 1.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL tog_sticky: got %b want 1", fail); end
    checks++; if (viol_cnt !== 16'd2) begin errors++; $display("FAIL tog_viol2: got %0d want 2", viol_cnt); end
    checks++; if (err_stamp !== 16'd0) begin errors++; $display("FAIL tog_hold: got %0d want 0", err_stamp); end
    err_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (err_stamp !== 16'd1) begin errors++; $display("FAIL tog_stamp2: got %0d want 1", err_stamp); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL tog_drained: got %b want 0", err_valid); end
  endtask

  task automatic test_z_and_rstval;
    err_ready = 1'b0;
    to_run(2);
    good(1'b1);                    // stamp 0, tq -> 1
    step(1'b0, 1'b0, 1'b1, 1'b0);  // z should be 1, stamp 1
    checks++; if (err_kind !== 2'd1) begin errors++; $display("FAIL z_kind: got %0d want 1", err_kind); end
    checks++; if (err_stamp !== 16'd1) begin errors++; $display("FAIL z_stamp: got %0d want 1", err_stamp); end
    good(1'b0);
    checks++; if (viol_cnt !== 16'd1) begin errors++; $display("FAIL z_viol: got %0d want 1", viol_cnt); end
    step(1'b1, 1'b0, 1'b1, 1'b0);  // reset with q stuck high
    step(1'b0, 1'b0, 1'b1, 1'b1);  // first cycle after reset: q must be 0
    checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL rst_valid: got %b want 1", err_valid); end
    checks++; if (err_kind !== 2'd2) begin errors++; $display("FAIL rst_kind: got %0d want 2", err_kind); end
    checks++; if (err_stamp !== 16'd0) begin errors++; $display("FAIL rst_stamp: got %0d want 0", err_stamp); end
    checks++; if (viol_cnt !== 16'd1) begin errors++; $display("FAIL rst_viol: got %0d want 1", viol_cnt); end
  endtask

  task automatic test_priority;
    err_ready = 1'b0;
    to_run(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);  // toggle and z both wrong
    checks++; if (err_kind !== 2'd0) begin errors++; $display("FAIL pri_kind: got %0d want 0", err_kind); end
    checks++; if (viol_cnt !== 16'd1) begin errors++; $display("FAIL pri_viol: got %0d want 1", viol_cnt); end
    err_ready = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1);  // consistent with q=1, en=0
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL pri_single: got %b want 0", err_valid); end
  endtask

  task automatic test_overflow;
    logic [15:0] exp_stamp;
    err_ready = 1'b0;
    to_run(2);
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1);  // z wrong each cycle, stamps 0..5
    checks++; if (viol_cnt !== 16'd6) begin errors++; $display("FAIL ovf_viol: got %0d want 6", viol_cnt); end
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
    checks++; if (err_stamp !== 16'd0) begin errors++; $display("FAIL ovf_head: got %0d want 0", err_stamp); end
    checks++; if (err_kind !== 2'd1) begin errors++; $display("FAIL ovf_kind: got %0d want 1", err_kind); end
    err_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      good(1'b0);
      exp_stamp = 16'(i);
      checks++; if (err_stamp !== exp_stamp) begin errors++; $display("FAIL ovf_order%0d: got %0d want %0d", i, err_stamp, exp_stamp); end
    end
    good(1'b0);
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", err_valid); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_stamp;
    err_ready = 1'b0;
    to_run(2);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);  // stamps 0..3, FIFO full
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL b2b_drop0: got %0d want 0", drop_cnt); end
    err_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);  // pop stamp 0, push stamp 4
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL b2b_drop: got %0d want 0", drop_cnt); end
    checks++; if (viol_cnt !== 16'd5) begin errors++; $display("FAIL b2b_viol: got %0d want 5", viol_cnt); end
    checks++; if (err_stamp !== 16'd1) begin errors++; $display("FAIL b2b_head: got %0d want 1", err_stamp); end
    for (int i = 2; i < 5; i++) begin
      good(1'b0);
      exp_stamp = 16'(i);
      checks++; if (err_stamp !== exp_stamp) begin errors++; $display("FAIL b2b_order%0d: got %0d want %0d", i, err_stamp, exp_stamp); end
    end
    good(1'b0);
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", err_valid); end
  endtask

  task automatic test_reset_midrun;
    logic seen_valid;
    err_ready = 1'b0;
    to_run(2);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b want 1", err_valid); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tq = 1'b0;
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", err_valid); end
    checks++; if (viol_cnt !== 16'd0) begin errors++; $display("FAIL mid_viol: got %0d want 0", viol_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_drop: got %0d want 0", drop_cnt); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL mid_fail: got %b want 0", fail); end
    seen_valid = 1'b0;
    repeat (4) begin
      good(1'b1);
      if (err_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL mid_clean: got %b want 0", seen_valid); end
  endtask

  task automatic test_hist;
    err_ready = 1'b0;
    to_run(2);
    good(1'b1);                    // {q,en} = 01
    good(1'b1);                    // 11
    good(1'b0);                    // 00
    step(1'b0, 1'b1, 1'b1, 1'b0);  // 11, toggle violation
    checks++; if (err_kind !== 2'd0) begin errors++; $display("FAIL hist_kind: got %0d want 0", err_kind); end
`ifdef TOGGLE_CHK_HIST_EN
    checks++; if (err_hist !== 8'h73) begin errors++; $display("FAIL hist_val: got %h want 73", err_hist); end
`else
    checks++; if (err_hist !== 8'h00) begin errors++; $display("FAIL hist_zero: got %h want 00", err_hist); end
`endif
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_z_and_rstval();
    test_priority();
    test_overflow();
    test_back_to_back();
    test_reset_midrun();
    test_hist();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
